// File: rtl/mux4_frame_sequencer.sv
// Feeder for a 4:1 mux: buffers one 4-bit word and steps sel across all four lanes
// so the mux output becomes a framed serial bitstream with valid/first/last flags.
module mux4_frame_sequencer #(
  parameter bit          MSB_FIRST  = 1'b0,
  parameter int unsigned GAP_CYCLES = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] in_data,
  output logic [3:0] lane,
  output logic [1:0] sel,
  output logic       ser_valid,
  output logic       ser_first,
  output logic       ser_last,
  output logic       busy
);

  typedef enum logic [1:0] {StIdle, StShift, StGap} state_e;

  localparam logic [1:0] SelStart = MSB_FIRST ? 2'd3 : 2'd0;
  // 2'd3 is -1 modulo 4
  localparam logic [1:0] SelStep  = MSB_FIRST ? 2'd3 : 2'd1;
  localparam logic [3:0] GapLast  = (GAP_CYCLES == 0) ? 4'd0 : 4'(GAP_CYCLES - 1);
  localparam bit         HasGap   = (GAP_CYCLES != 0);

  state_e     state_q, state_d;
  logic [3:0] pend_q, pend_d;
  logic       pend_valid_q, pend_valid_d;
  logic [3:0] lane_q, lane_d;
  logic [1:0] sel_q, sel_d;
  logic [1:0] beat_q, beat_d;
  logic [3:0] gap_q, gap_d;
  logic       ser_valid_q, ser_valid_d;
  logic       ser_first_q, ser_first_d;
  logic       ser_last_q, ser_last_d;

  logic accept, frame_end, gap_end, may_load, load;

  assign in_ready  = !pend_valid_q && !rst;
  assign accept    = in_valid && in_ready;
  assign frame_end = (state_q == StShift) && (beat_q == 2'd3);
  assign gap_end   = (state_q == StGap) && (gap_q == GapLast);
  // Without a gap the last beat hands straight over to the next word.
  assign may_load  = (state_q == StIdle) || gap_end || (frame_end && !HasGap);
  assign load      = may_load && pend_valid_q;

  always_comb begin
    state_d      = state_q;
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;
    lane_d       = lane_q;
    sel_d        = sel_q;
    beat_d       = beat_q;
    gap_d        = gap_q;
    ser_valid_d  = 1'b0;
    ser_first_d  = 1'b0;
    ser_last_d   = 1'b0;

    if (load) begin
      lane_d       = pend_q;
      sel_d        = SelStart;
      beat_d       = 2'd0;
      ser_valid_d  = 1'b1;
      ser_first_d  = 1'b1;
      pend_valid_d = 1'b0;
      state_d      = StShift;
    end else begin
      case (state_q)
        StShift: begin
          if (beat_q != 2'd3) begin
            beat_d      = beat_q + 2'd1;
            sel_d       = sel_q + SelStep;
            ser_valid_d = 1'b1;
            ser_last_d  = (beat_q == 2'd2);
          end else if (HasGap) begin
            gap_d   = 4'd0;
            state_d = StGap;
          end else begin
            state_d = StIdle;
          end
        end
        StGap: begin
          if (gap_end) begin
            state_d = StIdle;
          end else begin
            gap_d = gap_q + 4'd1;
          end
        end
        default: ;
      endcase
    end

    // accept and load are exclusive: accept needs the buffer empty, load needs it full.
    if (accept) begin
      pend_d       = in_data;
      pend_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      pend_q       <= 4'd0;
      pend_valid_q <= 1'b0;
      lane_q       <= 4'd0;
      sel_q        <= 2'd0;
      beat_q       <= 2'd0;
      gap_q        <= 4'd0;
      ser_valid_q  <= 1'b0;
      ser_first_q  <= 1'b0;
      ser_last_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
      lane_q       <= lane_d;
      sel_q        <= sel_d;
      beat_q       <= beat_d;
      gap_q        <= gap_d;
      ser_valid_q  <= ser_valid_d;
      ser_first_q  <= ser_first_d;
      ser_last_q   <= ser_last_d;
    end
  end

  assign lane      = lane_q;
  assign sel       = sel_q;
  assign ser_valid = ser_valid_q;
  assign ser_first = ser_first_q;
  assign ser_last  = ser_last_q;
  assign busy      = (state_q != StIdle) || pend_valid_q;

endmodule

// File: tb/tb_mux4_frame_sequencer.sv
// Bench for mux4_frame_sequencer: three configurations (LSB-first, MSB-first, gap of 3)
// checked against a word-to-beat-list reference model.
module tb_mux4_frame_sequencer;

  localparam int N = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid  [N];
  logic       in_ready  [N];
  logic [3:0] in_data   [N];
  logic [3:0] lane      [N];
  logic [1:0] sel       [N];
  logic       ser_valid [N];
  logic       ser_first [N];
  logic       ser_last  [N];
  logic       busy      [N];

  int cfg_gap [N];
  bit cfg_msb [N];

  typedef struct packed {
    logic [3:0] w;
    logic [1:0] s;
    logic       b;
    logic       f;
    logic       l;
  } beat_t;

  beat_t      exp_q[$];
  logic [3:0] words[$];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mux4_frame_sequencer #(.MSB_FIRST(1'b0), .GAP_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_data(in_data[0]), .lane(lane[0]), .sel(sel[0]), .ser_valid(ser_valid[0]),
    .ser_first(ser_first[0]), .ser_last(ser_last[0]), .busy(busy[0])
  );

  mux4_frame_sequencer #(.MSB_FIRST(1'b1), .GAP_CYCLES(0)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_data(in_data[1]), .lane(lane[1]), .sel(sel[1]), .ser_valid(ser_valid[1]),
    .ser_first(ser_first[1]), .ser_last(ser_last[1]), .busy(busy[1])
  );

  mux4_frame_sequencer #(.MSB_FIRST(1'b0), .GAP_CYCLES(3)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .in_data(in_data[2]), .lane(lane[2]), .sel(sel[2]), .ser_valid(ser_valid[2]),
    .ser_first(ser_first[2]), .ser_last(ser_last[2]), .busy(busy[2])
  );

  // Drives the queued words into DUT d and checks every serial beat against the model.
  // hold=1 keeps in_valid high, so every inter-frame gap must be exactly GAP_CYCLES.
  task automatic stream(input int d, input bit hold, input string name);
    int         k = 0;
    int         n = words.size();
    bit         acc_prev = 1'b0;
    int         idle = -1;
    bit         watch = 1'b0;
    int         lat = 0;
    bit         done = 1'b0;
    int         idx;
    logic [3:0] w;
    logic [3:0] lv;
    logic       mux;
    beat_t      e;
    exp_q.delete();
    @(posedge clk); #1;
    in_valid[d] = (k < n) && (hold || ($urandom_range(0, 1) == 1));
    in_data[d]  = (k < n) ? words[k] : 4'($urandom);
    for (int cyc = 0; cyc < 400 && !done; cyc++) begin
      @(negedge clk);
      lat++;
      if (acc_prev) begin
        checks++;
        if (in_ready[d] !== 1'b0 || busy[d] !== 1'b1) begin
          errors++;
          $display("FAIL %s after_accept: in_ready=%b busy=%b, want in_ready=0 busy=1",
                   name, in_ready[d], busy[d]);
        end
      end
      if (ser_valid[d] === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL %s extra_beat: sel=%0d lane=%h, want no valid beat", name, sel[d],
                   lane[d]);
        end else begin
          e   = exp_q.pop_front();
          lv  = lane[d];
          mux = lv[sel[d]];
          if (sel[d] !== e.s || lv !== e.w || mux !== e.b || ser_first[d] !== e.f ||
              ser_last[d] !== e.l) begin
            errors++;
            $display("FAIL %s beat: sel=%0d lane=%h out=%b first=%b last=%b, want sel=%0d lane=%h out=%b first=%b last=%b",
                     name, sel[d], lv, mux, ser_first[d], ser_last[d], e.s, e.w, e.b, e.f, e.l);
          end
        end
        if (ser_first[d] === 1'b1) begin
          if (watch) begin
            checks++;
            // Accept edge N, first beat visible after edge N+1.
            if (lat != 2) begin
              errors++;
              $display("FAIL %s latency: first beat %0d negedges after accept, want 2",
                       name, lat);
            end
            watch = 1'b0;
          end
          if (idle >= 0) begin
            checks++;
            if ((hold && idle != cfg_gap[d]) || (!hold && idle < cfg_gap[d])) begin
              errors++;
              $display("FAIL %s gap: %0d idle cycles between frames, want %s%0d", name, idle,
                       hold ? "" : ">=", cfg_gap[d]);
            end
          end
        end
        idle = (ser_last[d] === 1'b1) ? 0 : -1;
      end else begin
        checks++;
        if (ser_first[d] !== 1'b0 || ser_last[d] !== 1'b0) begin
          errors++;
          $display("FAIL %s flags_idle: first=%b last=%b, want 0 0", name, ser_first[d],
                   ser_last[d]);
        end
        if (idle >= 0) idle++;
      end
      acc_prev = in_valid[d] && in_ready[d];
      if (acc_prev) begin
        if (busy[d] === 1'b0) begin
          watch = 1'b1;
          lat   = 0;
        end
        w = words[k];
        for (int i = 0; i < 4; i++) begin
          idx = cfg_msb[d] ? 3 - i : i;
          exp_q.push_back('{w: w, s: 2'(idx), b: w[idx], f: (i == 0), l: (i == 3)});
        end
        k++;
      end
      if (k == n && exp_q.size() == 0 && busy[d] === 1'b0 && ser_valid[d] === 1'b0 && !acc_prev)
        done = 1'b1;
      @(posedge clk); #1;
      in_valid[d] = (k < n) && (hold || ($urandom_range(0, 1) == 1));
      in_data[d]  = (k < n) ? words[k] : 4'($urandom);
    end
    in_valid[d] = 1'b0;
    checks++;
    if (!done || k != n || exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s completion: accepted %0d of %0d, %0d beats outstanding, want all done",
               name, k, n, exp_q.size());
    end
  endtask

  task automatic check_zero(input string name);
    for (int d = 0; d < N; d++) begin
      checks++;
      if (in_ready[d] !== 1'b0 || ser_valid[d] !== 1'b0 || ser_first[d] !== 1'b0 ||
          ser_last[d] !== 1'b0 || busy[d] !== 1'b0 || sel[d] !== 2'd0 || lane[d] !== 4'd0) begin
        errors++;
        $display("FAIL %s dut%0d: rdy=%b v=%b f=%b l=%b busy=%b sel=%0d lane=%h, want all 0",
                 name, d, in_ready[d], ser_valid[d], ser_first[d], ser_last[d], busy[d], sel[d],
                 lane[d]);
      end
    end
  endtask

  task automatic check_released(input string name);
    for (int d = 0; d < N; d++) begin
      checks++;
      if (in_ready[d] !== 1'b1 || ser_valid[d] !== 1'b0 || busy[d] !== 1'b0) begin
        errors++;
        $display("FAIL %s dut%0d: in_ready=%b ser_valid=%b busy=%b, want 1 0 0", name, d,
                 in_ready[d], ser_valid[d], busy[d]);
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    for (int d = 0; d < N; d++) begin
      in_valid[d] = 1'b1;
      in_data[d]  = 4'hA;
    end
    #1 check_zero("reset_hold");
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < N; d++) in_valid[d] = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    #1 check_released("reset_release");
  endtask

  task automatic test_single;
    words = '{4'b1010};
    stream(0, 1'b1, "single");
  endtask

  task automatic test_msb_first;
    words = '{4'b0110};
    stream(1, 1'b1, "msb_first");
  endtask

  task automatic test_back_to_back;
    words = '{4'b0001, 4'b1110};
    stream(0, 1'b1, "back_to_back");
  endtask

  task automatic test_gap;
    words = '{4'b1011, 4'b0100};
    stream(2, 1'b1, "gap");
  endtask

  task automatic test_backpressure;
    words.delete();
    for (int i = 0; i < 5; i++) words.push_back(4'($urandom));
    stream(0, 1'b1, "backpressure");
  endtask

  task automatic test_random;
    for (int d = 0; d < N; d++) begin
      words.delete();
      for (int i = 0; i < 8; i++) words.push_back(4'($urandom));
      stream(d, 1'b0, $sformatf("random_dut%0d", d));
    end
  endtask

  task automatic test_reset_midframe;
    @(posedge clk); #1;
    in_valid[0] = 1'b1;
    in_data[0]  = 4'hF;
    @(posedge clk); #1;
    in_data[0] = 4'h5;
    repeat (2) @(posedge clk);
    #1;
    in_valid[0] = 1'b0;
    checks++;
    if (ser_valid[0] !== 1'b1 || busy[0] !== 1'b1) begin
      errors++;
      $display("FAIL midframe_setup: ser_valid=%b busy=%b, want 1 1", ser_valid[0], busy[0]);
    end
    #2 rst = 1'b1;
    #1 check_zero("midframe_reset");
    @(posedge clk); #1;
    rst = 1'b0;
    #1 check_released("midframe_release");
    repeat (3) @(negedge clk);
    checks++;
    if (busy[0] !== 1'b0 || ser_valid[0] !== 1'b0) begin
      errors++;
      $display("FAIL midframe_discard: busy=%b ser_valid=%b, want 0 0", busy[0], ser_valid[0]);
    end
  endtask

  initial begin
    cfg_gap = '{0, 0, 3};
    cfg_msb = '{1'b0, 1'b1, 1'b0};
    for (int d = 0; d < N; d++) begin
      in_valid[d] = 1'b0;
      in_data[d]  = 4'd0;
    end
    test_reset;
    test_single;
    test_msb_first;
    test_back_to_back;
    test_gap;
    test_backpressure;
    test_random;
    test_reset_midframe;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mux4_frame_sequencer.md
# mux4_frame_sequencer

Upstream feeder for the 4:1 mux stage. It accepts 4-bit parallel words over a valid/ready handshake and buffers one pending word. It presents the active word on the mux data inputs and steps the mux select through all four lanes, one lane per clock, so the mux output becomes a framed serial bitstream. It also drives frame valid, first and last flags alongside the select.

## Interface
- MSB_FIRST, default 0: 0 steps sel 0→1→2→3 (lane0 first); 1 steps sel 3→2→1→0.
- GAP_CYCLES, default 0, legal range 0–15: idle cycles inserted after each frame, with ser_valid low.

- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  reset, asynchronous and active-high.
- in_valid  input  1  in_data is valid this cycle.
- in_ready  output  1  block can accept a word this cycle.
- in_data  input  4  parallel word; bit i feeds lane i.
- lane  output  4  held word; lane[0..3] drive the mux in0..in3.
- sel  output  2  mux select.
- ser_valid  output  1  the current sel/lane beat is a valid serial bit.
- ser_first  output  1  first beat of a frame.
- ser_last  output  1  fourth (last) beat of a frame.
- busy  output  1  a frame or gap is in progress, or a word is pending.

## Operation
- Pending buffer: one 4-bit register plus pend_valid.
  - in_ready = !pend_valid && !rst.
  - A transfer occurs when in_valid && in_ready at a clk edge; it captures in_data into the buffer.
  - No pass-through: a word that is draining from the buffer on an edge does not free in_ready on that same edge.
- States: IDLE, SHIFT, GAP.
  - IDLE: if pend_valid, load lane ← pend, sel ← start index (0, or 3 if MSB_FIRST), set ser_valid=1 and ser_first=1, clear pend_valid, go to SHIFT. Otherwise hold with ser_valid=0.
  - SHIFT: beat counter runs 0..3. sel advances by +1 (or −1) each clock. ser_first is high on beat 0 only; ser_last is high on beat 3 only. lane is stable for all four beats.
  - After beat 3:
    - GAP_CYCLES>0: go to GAP, ser_valid=0.
    - GAP_CYCLES=0 and pend_valid: load the next word directly. This is a back-to-back frame with no bubble.
    - Otherwise: go to IDLE.
  - GAP: count GAP_CYCLES clocks with ser_valid=0. Then behave as IDLE on the next edge: load if pend_valid, otherwise go to IDLE.
- In IDLE and GAP, sel and lane hold their last values. ser_first and ser_last are 0 whenever ser_valid=0.
- Counters: 2-bit beat counter and 4-bit gap counter. sel arithmetic wraps modulo 4 but never crosses a frame boundary.
- busy = (state≠IDLE) || pend_valid.

## Timing
- Reset (async, takes effect immediately while rst=1): sel=0, lane=0, ser_valid=0, ser_first=0, ser_last=0, busy=0, pend_valid=0, in_ready=0, state=IDLE.
- in_ready rises combinationally once rst deasserts.
- All outputs except in_ready are registered.
- Latency, with the block idle: word accepted at edge N. At edge N+1: lane=word, first beat with ser_valid=1. At edge N+4: ser_last=1.
- Sustained throughput with GAP_CYCLES=0: one word per 4 clocks. The single pending buffer is sufficient for this rate.
- in_ready timing: drops the cycle after an accept and rises again after the edge that loads the pending word into lane.
- Reset mid-frame: the frame is abandoned and the pending word is discarded. After rst deasserts, the block starts from IDLE.
- in_valid during rst is ignored.

## Test plan
- Reset: assert rst mid-frame → all outputs are 0 immediately and in_ready=0. Deassert → in_ready=1, ser_valid=0.
- Single word 4'b1010, MSB_FIRST=0:
  - sel=0,1,2,3 on the four clocks after the accept.
  - mux out = 0,1,0,1.
  - ser_first on beat 0, ser_last on beat 3.
  - ser_valid=0 afterwards.
- Back-to-back words A=4'b0001 and B=4'b1110 held on in_valid, GAP_CYCLES=0:
  - 8 contiguous valid beats.
  - B's ser_first immediately follows A's ser_last.
  - in_ready deasserts while B is pending.
- MSB_FIRST=1 with word 4'b0110: sel=3,2,1,0 and out=0,1,1,0.
- GAP_CYCLES=3, two queued words: exactly 3 cycles with ser_valid=0 between A's ser_last and B's ser_first.
- Backpressure: in_valid held high continuously for 5 words → each word is accepted exactly once, and the serial output order matches the input order with no loss or duplication.
